// File: rtl/pic_cmd_sequencer.sv
// Bus-cycle sequencer for an 8259-style PIC: runs the ICW init sequence, single OCW writes
// and single status reads, each as SETUP / STROBE / HOLD / GAP on a CS/WR/RD bus.
module pic_cmd_sequencer #(
  parameter int WR_PULSE = 2,
  parameter int RD_PULSE = 2,
  parameter int GAP      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  input  logic [7:0] icw1_val,
  input  logic [7:0] icw2_val,
  input  logic [7:0] icw3_val,
  input  logic [7:0] icw4_val,
  input  logic       ocw_req,
  input  logic       ocw_a0,
  input  logic [7:0] ocw_data,
  input  logic       rd_req,
  input  logic [7:0] bus_din,
  output logic       CS,
  output logic       write,
  output logic       Read,
  output logic       A0,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  output logic       busy,
  output logic       ack,
  output logic       init_done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;
  typedef enum logic [1:0] {OP_INIT, OP_OCW, OP_RD} op_t;

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [1:0] step_q, step_d;
  logic [2:0] cnt_q, cnt_d;
  logic       a0_q, a0_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
  logic       ack_q, ack_d, err_q, err_d, done_q, done_d, rdv_q, rdv_d;
  logic [7:0] rdat_q, rdat_d;

  // Next ICW after the current step: ICW3 only in cascade mode, ICW4 only when requested.
  logic       has_next;
  logic [1:0] nstep;
  logic [7:0] nbyte;

  always_comb begin
    has_next = 1'b0;
    nstep    = step_q;
    case (step_q)
      2'd0: begin has_next = 1'b1; nstep = 2'd1; end
      2'd1: begin
        if (!icw1_q[1])     begin has_next = 1'b1; nstep = 2'd2; end
        else if (icw1_q[0]) begin has_next = 1'b1; nstep = 2'd3; end
      end
      2'd2: if (icw1_q[0]) begin has_next = 1'b1; nstep = 2'd3; end
      default: has_next = 1'b0;
    endcase
    case (nstep)
      2'd1:    nbyte = icw2_q;
      2'd2:    nbyte = icw3_q;
      2'd3:    nbyte = icw4_q;
      default: nbyte = icw1_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    a0_d    = a0_q;
    dout_d  = dout_q;
    icw1_d  = icw1_q;
    icw2_d  = icw2_q;
    icw3_d  = icw3_q;
    icw4_d  = icw4_q;
    done_d  = done_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdv_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_init) begin
          op_d    = OP_INIT;
          step_d  = 2'd0;
          icw1_d  = icw1_val;
          icw2_d  = icw2_val;
          icw3_d  = icw3_val;
          icw4_d  = icw4_val;
          dout_d  = icw1_val;
          a0_d    = 1'b0;
          done_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = S_SETUP;
        end else if (ocw_req) begin
          if (done_q) begin
            op_d    = OP_OCW;
            dout_d  = ocw_data;
            a0_d    = ocw_a0;
            ack_d   = 1'b1;
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end else if (rd_req) begin
          if (done_q) begin
            op_d    = OP_RD;
            a0_d    = 1'b0;
            ack_d   = 1'b1;
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = (op_q == OP_RD) ? 3'(RD_PULSE - 1) : 3'(WR_PULSE - 1);
      end
      S_STROBE: begin
        if (cnt_q == 3'd0) begin
          state_d = S_HOLD;
          if (op_q == OP_RD) begin
            rdat_d = bus_din;
            rdv_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_HOLD: begin
        state_d = S_GAP;
        cnt_d   = 3'(GAP - 1);
      end
      S_GAP: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (op_q == OP_INIT && has_next) begin
          step_d  = nstep;
          dout_d  = nbyte;
          a0_d    = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
          if (op_q == OP_INIT) done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_INIT;
      step_q  <= 2'd0;
      cnt_q   <= 3'd0;
      a0_q    <= 1'b0;
      dout_q  <= 8'h00;
      icw1_q  <= 8'h00;
      icw2_q  <= 8'h00;
      icw3_q  <= 8'h00;
      icw4_q  <= 8'h00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rdat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      a0_q    <= a0_d;
      dout_q  <= dout_d;
      icw1_q  <= icw1_d;
      icw2_q  <= icw2_d;
      icw3_q  <= icw3_d;
      icw4_q  <= icw4_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdv_q   <= rdv_d;
      rdat_q  <= rdat_d;
    end
  end

  // Bus pins decode straight from state so a reset edge releases them immediately.
  logic in_cyc;
  assign in_cyc    = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign CS        = ~in_cyc;
  assign write     = ~((state_q == S_STROBE) && (op_q != OP_RD));
  assign Read      = ~((state_q == S_STROBE) && (op_q == OP_RD));
  assign bus_oe    = in_cyc && (op_q != OP_RD);
  assign busy      = (state_q != S_IDLE);
  assign A0        = a0_q;
  assign bus_dout  = dout_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign init_done = done_q;
  assign rd_data   = rdat_q;
  assign rd_valid  = rdv_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Scoreboard bench for pic_cmd_sequencer: expected bus writes / read bytes are queued when a
// request is issued and popped by a bus monitor as the strobes and rd_valid appear.
module tb_pic_cmd_sequencer;
  localparam int WR_PULSE = 2;
  localparam int RD_PULSE = 2;
  localparam int GAP      = 1;

  logic       clk = 1'b0, reset = 1'b1;
  logic       start_init = 1'b0, ocw_req = 1'b0, ocw_a0 = 1'b0, rd_req = 1'b0;
  logic [7:0] icw1_val = 8'h0, icw2_val = 8'h0, icw3_val = 8'h0, icw4_val = 8'h0;
  logic [7:0] ocw_data = 8'h0, bus_din = 8'h0;
  logic       CS, write, Read, A0, bus_oe, busy, ack, init_done, rd_valid, err;
  logic [7:0] bus_dout, rd_data;

  pic_cmd_sequencer #(.WR_PULSE(WR_PULSE), .RD_PULSE(RD_PULSE), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start_init(start_init),
    .icw1_val(icw1_val), .icw2_val(icw2_val), .icw3_val(icw3_val), .icw4_val(icw4_val),
    .ocw_req(ocw_req), .ocw_a0(ocw_a0), .ocw_data(ocw_data), .rd_req(rd_req),
    .bus_din(bus_din), .CS(CS), .write(write), .Read(Read), .A0(A0), .bus_dout(bus_dout),
    .bus_oe(bus_oe), .busy(busy), .ack(ack), .init_done(init_done), .rd_data(rd_data),
    .rd_valid(rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [8:0] exp_wr[$];
  logic [7:0] exp_rd[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: strobe content, widths, stability and read returns.
  int wlow = 0, rlow = 0;
  logic [8:0] wcap;
  always @(negedge clk) begin
    if (reset) begin
      wlow = 0;
      rlow = 0;
    end else begin
      chk("rw_excl", {31'd0, (!write && !Read)}, 0);
      if (!write) begin
        if (wlow == 0) begin
          wcap = {A0, bus_dout};
          if (exp_wr.size() == 0) chk("wr_unexpected", {23'd0, wcap}, 32'h1ff);
          else chk("wr_a0_data", {23'd0, wcap}, {23'd0, exp_wr.pop_front()});
          chk("wr_cs_oe", {30'd0, CS, bus_oe}, 32'b01);
        end else begin
          chk("wr_stable", {22'd0, CS, A0, bus_dout}, {22'd0, 1'b0, wcap});
        end
        wlow++;
      end else if (wlow != 0) begin
        chk("wr_width", wlow, WR_PULSE);
        wlow = 0;
      end
      if (!Read) begin
        chk("rd_cs_oe", {30'd0, CS, bus_oe}, 32'b00);
        rlow++;
      end else if (rlow != 0) begin
        chk("rd_width", rlow, RD_PULSE);
        rlow = 0;
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
      end
    end
  end

  task automatic pulse(input logic si, input logic oc, input logic rd);
    @(negedge clk);
    start_init = si; ocw_req = oc; rd_req = rd;
    @(negedge clk);
    start_init = 1'b0; ocw_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("busy_timeout", 1, 0);
  endtask

  task automatic run_init(input logic [7:0] i1, i2, i3, i4, input int exp_busy);
    int n;
    icw1_val = i1; icw2_val = i2; icw3_val = i3; icw4_val = i4;
    exp_wr.push_back({1'b0, i1});
    exp_wr.push_back({1'b1, i2});
    if (!i1[1]) exp_wr.push_back({1'b1, i3});
    if (i1[0])  exp_wr.push_back({1'b1, i4});
    pulse(1'b1, 1'b0, 1'b0);
    chk("init_ack", {29'd0, ack, busy, init_done}, 32'b110);
    wait_idle(n);
    chk("init_busy_len", n, exp_busy);
    chk("init_done", {31'd0, init_done}, 1);
    chk("init_q_empty", exp_wr.size(), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_outs", {12'd0, CS, write, Read, A0, bus_dout, bus_oe, busy, ack, init_done,
                       rd_data, rd_valid, err}, {12'd0, 3'b111, 1'b0, 8'h00, 4'b0000, 8'h00, 2'b00});
    reset = 1'b0;

    // OCW / read before init are rejected without bus activity
    ocw_a0 = 1'b0; ocw_data = 8'h20;
    pulse(1'b0, 1'b1, 1'b0);
    chk("pre_ocw_err", {29'd0, err, ack, CS}, 32'b101);
    pulse(1'b0, 1'b0, 1'b1);
    chk("pre_rd_err", {28'd0, err, ack, CS, busy}, 32'b1010);
    @(negedge clk);
    chk("err_one_clk", {31'd0, err}, 0);

    run_init(8'h13, 8'h08, 8'hAA, 8'h01, 15);   // single, ICW4, no ICW3
    run_init(8'h10, 8'h20, 8'h04, 8'h77, 15);   // cascade, no ICW4
    run_init(8'h11, 8'h40, 8'h02, 8'h03, 20);   // cascade with ICW4

    // OCW writes pass data unmodified
    ocw_a0 = 1'b0; ocw_data = 8'h20;
    exp_wr.push_back({1'b0, 8'h20});
    pulse(1'b0, 1'b1, 1'b0);
    chk("ocw_ack", {30'd0, ack, err}, 32'b10);
    wait_idle(n);
    chk("ocw_busy_len", n, 2 + WR_PULSE + GAP);
    ocw_a0 = 1'b1; ocw_data = 8'hFB;
    exp_wr.push_back({1'b1, 8'hFB});
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle(n);
    chk("ocw_q_empty", exp_wr.size(), 0);

    // status reads
    bus_din = 8'h5A; exp_rd.push_back(8'h5A);
    pulse(1'b0, 1'b0, 1'b1);
    chk("rd_ack", {31'd0, ack}, 1);
    wait_idle(n);
    chk("rd_busy_len", n, 2 + RD_PULSE + GAP);
    bus_din = 8'hC3; exp_rd.push_back(8'hC3);
    pulse(1'b0, 1'b0, 1'b1);
    wait_idle(n);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("rd_hold", {24'd0, rd_data}, 32'hC3);

    // simultaneous OCW + read: OCW wins; request during busy ignored
    ocw_a0 = 1'b1; ocw_data = 8'h55;
    exp_wr.push_back({1'b1, 8'h55});
    pulse(1'b0, 1'b1, 1'b1);
    chk("prio_ack", {31'd0, ack}, 1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("busy_ignore", {29'd0, ack, err, busy}, 32'b001);
    wait_idle(n);
    repeat (3) @(negedge clk);
    chk("no_queued", {30'd0, CS, busy}, 32'b10);
    chk("prio_q_empty", exp_wr.size() + exp_rd.size(), 0);

    // reset during ICW2 strobe
    icw1_val = 8'h13; icw2_val = 8'h08; icw3_val = 8'hAA; icw4_val = 8'h01;
    exp_wr.push_back({1'b0, 8'h13});
    exp_wr.push_back({1'b1, 8'h08});
    pulse(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(!write && A0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("reach_icw2", {31'd0, (n < 100)}, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_abort", {28'd0, write, CS, init_done, busy}, 32'b1100);
    @(negedge clk);
    chk("abort_no_strobe", {29'd0, write, Read, CS}, 32'b111);
    exp_wr.delete();
    reset = 1'b0;
    run_init(8'h13, 8'h08, 8'hAA, 8'h01, 15);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pic_cmd_sequencer.md
PIC_CMD_SEQUENCER -- requirements
Module: pic_cmd_sequencer

Interface
REQ-001 Parameter WR_PULSE, default 2, write-strobe low width in clocks (legal 1..7).
REQ-002 Parameter RD_PULSE, default 2, read-strobe low width in clocks (legal 1..7).
REQ-003 Parameter GAP, default 1, CS-high clocks between bus cycles (legal 1..7).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start_init  in  1  request to run the ICW sequence.
REQ-007 icw1_val, icw2_val, icw3_val, icw4_val  in  8 each  ICW bytes; sampled on start_init acceptance.
REQ-008 ocw_req  in  1  request one OCW write.
REQ-009 ocw_a0  in  1  A0 for the OCW (1 = OCW1, 0 = OCW2/OCW3).
REQ-010 ocw_data  in  8  OCW byte.
REQ-011 rd_req  in  1  request one status read.
REQ-012 bus_din  in  8  data returned by the PIC during read strobe.
REQ-013 CS  out  1  chip select, active low.
REQ-014 write  out  1  write strobe, active low.
REQ-015 Read  out  1  read strobe, active low.
REQ-016 A0  out  1  address bit to PIC.
REQ-017 bus_dout  out  8  write data to PIC.
REQ-018 bus_oe  out  1  high while sequencer drives bus_dout.
REQ-019 busy  out  1  high from acceptance until GAP end of last bus cycle.
REQ-020 ack  out  1  one-clock pulse on request acceptance.
REQ-021 init_done  out  1  high after ICW sequence completes.
REQ-022 rd_data  out  8  captured read byte; rd_valid  out  1  one-clock pulse when rd_data updates.
REQ-023 err  out  1  one-clock pulse on rejected request.

Function
REQ-024 Requests SHALL be sampled only when busy is low; requests while busy are ignored, not queued, and not flagged.
REQ-025 Simultaneous requests SHALL be prioritised start_init > ocw_req > rd_req; losers are dropped.
REQ-026 Bus-cycle FSM states: IDLE, SETUP, STROBE, HOLD, GAP.
REQ-027 SETUP (1 clk): CS=0, A0 and bus_dout valid, bus_oe=1 for writes, strobes high.
REQ-028 STROBE: write=0 (or Read=0) for exactly WR_PULSE (RD_PULSE) clocks; A0, data, CS stable.
REQ-029 HOLD (1 clk): strobe high, CS=0, A0/data unchanged; GAP: CS=1, bus_oe=0 for GAP clocks.
REQ-030 Read cycles SHALL capture bus_din on the last STROBE clock; rd_data/rd_valid update in HOLD.
REQ-031 Init sequence: ICW1 (A0=0), ICW2 (A0=1), ICW3 (A0=1) only if icw1_val[1]=0, ICW4 (A0=1) only if icw1_val[0]=1, in that order, back to back with GAP between.
REQ-032 Write-cycle length SHALL be 2+WR_PULSE+GAP clocks; busy covers all cycles of a sequence without dropping between them.
REQ-033 init_done SHALL clear on start_init acceptance and set in the clock after the final ICW's GAP, same clock busy falls.
REQ-034 ocw_req or rd_req while init_done=0 SHALL be rejected: err pulse, no ack, no bus activity.
REQ-035 start_init while init_done=1 SHALL be accepted and re-run the full sequence.
REQ-036 OCW writes SHALL pass ocw_data unmodified; no decoding of OCW2 vs OCW3.
REQ-037 Outside SETUP/STROBE/HOLD: CS=1, write=1, Read=1, bus_oe=0; write and Read never low together.

Reset
REQ-038 Reset SHALL force in the same edge: state IDLE, CS=1, write=1, Read=1, A0=0, bus_dout=0, bus_oe=0, busy=0, ack=0, init_done=0, rd_data=0, rd_valid=0, err=0.
REQ-039 Reset mid-cycle SHALL abort with no further strobe edges; the partial cycle is not resumed.

Verification
REQ-040 icw1_val=0x13, icw2_val=0x08, start_init -> writes 0x13/A0=0, 0x08/A0=1, 0x01/A0=1 (icw4_val=0x01), no ICW3; init_done after 3x5=15 clocks of busy.
REQ-041 icw1_val=0x10, cascade -> writes ICW1, ICW2, ICW3 only; ICW4 never driven.
REQ-042 ocw_req before init -> err pulse, CS stays 1; after init, ocw_a0=0, ocw_data=0x20 -> one write, write low exactly 2 clocks.
REQ-043 rd_req with bus_din=0x5A during strobe -> Read low 2 clocks, rd_data=0x5A, rd_valid one pulse, bus_oe=0 throughout.
REQ-044 ocw_req and rd_req same clock -> OCW write only; rd_req dropped; second request during busy ignored.
REQ-045 reset asserted during STROBE of ICW2 -> next edge write=1, CS=1, init_done=0; subsequent start_init runs full sequence from ICW1.
